// File: rtl/iq_samp_fifo_pkg.sv
// Shared constants, sample type and sizing helper for the IQ sample FIFO.
package iq_samp_fifo_pkg;

  localparam int SAMP_W_DEF = 24;
  localparam int DEPTH_DEF  = 8;

  // One {I,Q} entry at the default component width; modules with other widths declare the same layout locally
  typedef struct packed {
    logic [SAMP_W_DEF-1:0] i;
    logic [SAMP_W_DEF-1:0] q;
  } iq_samp_t;

  // Pointer/occupancy width: one extra bit so a full FIFO is distinguishable from an empty one
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_samp_ram.sv
// Sample storage: one synchronous write port and one asynchronous read port, no reset on contents.
module iq_samp_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/iq_samp_fifo.sv
// First-word-fall-through FIFO of {I,Q} sample pairs with occupancy, threshold
// status and sticky overflow/underflow flags.
module iq_samp_fifo
  import iq_samp_fifo_pkg::*;
#(
  parameter int SAMP_W    = SAMP_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic [SAMP_W-1:0]        SampI,
  input  logic [SAMP_W-1:0]        SampQ,
  input  logic                     PullOut,
  output logic [SAMP_W-1:0]        OutI,
  output logic [SAMP_W-1:0]        OutQ,
  output logic                     Full,
  output logic                     Empty,
  output logic                     AlmostFull,
  output logic                     AlmostEmpty,
  output logic [cnt_w(DEPTH)-1:0]  Count,
  output logic                     Overflow,
  output logic                     Underflow,
  input  logic                     ClrErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] PTR_ONE  = {{PW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  typedef struct packed {
    logic [SAMP_W-1:0] i;
    logic [SAMP_W-1:0] q;
  } samp_t;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4) || (DEPTH > 256)) begin : g_depth_chk
    $error("iq_samp_fifo: DEPTH must be a power of two between 4 and 256");
  end
  if (!((AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH))) begin : g_th_chk
    $error("iq_samp_fifo: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [CW-1:0] wr_ptr_r, rd_ptr_r, count_r;
  logic [CW-1:0] wr_nxt_s, rd_nxt_s;
  logic          ovf_r, unf_r;
  logic          empty_s, full_s;
  logic          push_ok_s, pull_ok_s, ovf_ev_s, unf_ev_s;
  samp_t         wr_samp_s, rd_samp_s;

  assign empty_s = (rd_ptr_r == wr_ptr_r);
  assign full_s  = (rd_ptr_r[PW-1:0] == wr_ptr_r[PW-1:0]) && (rd_ptr_r[PW] != wr_ptr_r[PW]);

  // A full FIFO still takes a push when the head leaves on the same edge
  assign push_ok_s = PushIn & (~full_s | PullOut);
  assign pull_ok_s = PullOut & ~empty_s;
  assign ovf_ev_s  = PushIn & full_s & ~PullOut;
  assign unf_ev_s  = PullOut & empty_s;

  // Next pointer values; the extra wrap bit makes the increment roll over at 2*DEPTH on its own
  always_comb begin
    wr_nxt_s = wr_ptr_r;
    rd_nxt_s = rd_ptr_r;
    if (push_ok_s) begin
      wr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    if (pull_ok_s) begin
      rd_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_r <= {CW{1'b0}};
      rd_ptr_r <= {CW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      count_r  <= wr_nxt_s - rd_nxt_s;
      ovf_r    <= ovf_ev_s | (ovf_r & ~ClrErr);
      unf_r    <= unf_ev_s | (unf_r & ~ClrErr);
    end
  end

  assign wr_samp_s = '{i: SampI, q: SampQ};

  iq_samp_ram #(
    .W     (2 * SAMP_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (Clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r[PW-1:0]),
    .wdata (wr_samp_s),
    .raddr (rd_ptr_r[PW-1:0]),
    .rdata (rd_samp_s)
  );

  // Stale memory behind an empty FIFO is never exposed
  assign OutI        = empty_s ? {SAMP_W{1'b0}} : rd_samp_s.i;
  assign OutQ        = empty_s ? {SAMP_W{1'b0}} : rd_samp_s.q;
  assign Full        = full_s;
  assign Empty       = empty_s;
  assign AlmostFull  = (count_r >= AFULL_C);
  assign AlmostEmpty = (count_r <= AEMPTY_C);
  assign Count       = count_r;
  assign Overflow    = ovf_r;
  assign Underflow   = unf_r;

endmodule

// File: tb/tb_iq_samp_fifo.sv
// Directed bench for iq_samp_fifo (DEPTH=8, SAMP_W=24): stimulus queues expected
// head samples, a negedge monitor checks every accepted pull against that queue.
module tb_iq_samp_fifo;
  import iq_samp_fifo_pkg::*;

  localparam int SAMP_W = 24;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset, push_in, pull_out, clr_err;
  logic [SAMP_W-1:0] samp_i, samp_q, out_i, out_q;
  logic              full, empty, afull, aempty, ovf, unf;
  logic [3:0]        count;

  int       n_cmp = 0;
  int       n_err = 0;
  iq_samp_t exp_q[$];

  iq_samp_fifo #(.SAMP_W(SAMP_W), .DEPTH(DEPTH)) dut (
    .Clk(clk), .Reset(reset), .PushIn(push_in), .SampI(samp_i), .SampQ(samp_q),
    .PullOut(pull_out), .OutI(out_i), .OutQ(out_q), .Full(full), .Empty(empty),
    .AlmostFull(afull), .AlmostEmpty(aempty), .Count(count),
    .Overflow(ovf), .Underflow(unf), .ClrErr(clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a pull about to be accepted must present the oldest expected sample
  always @(negedge clk) begin
    if (!reset && pull_out && !empty) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL head: unexpected pull data I=%0d Q=%0d", out_i, out_q);
      end else begin
        iq_samp_t e;
        e = exp_q.pop_front();
        if ((out_i != e.i) || (out_q != e.q)) begin
          n_err++;
          $display("FAIL head: got I=%0d Q=%0d, expected I=%0d Q=%0d", out_i, out_q, e.i, e.q);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle; acc says whether this push is expected to be stored
  task automatic cyc(input logic push, input int iv, input int qv, input logic pull, input logic acc);
    push_in  = push;
    pull_out = pull;
    samp_i   = SAMP_W'(iv);
    samp_q   = SAMP_W'(qv);
    if (push && acc) exp_q.push_back('{i: SAMP_W'(iv), q: SAMP_W'(qv)});
    tick();
    push_in  = 1'b0;
    pull_out = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push_in = 1'b0; pull_out = 1'b0; clr_err = 1'b0;
    samp_i = '0; samp_q = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", aempty, 1);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_out", {out_i, out_q}, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);

    // Fill 1..8 / 101..108
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, k, 100 + k, 1'b0, 1'b1);
      check("fill_count", count, k);
      check("fill_afull", afull, (k >= 6) ? 1 : 0);
      check("fill_aempty", aempty, (k <= 2) ? 1 : 0);
      check("fill_outi", out_i, 1);
    end
    check("fill_full", full, 1);

    // Push onto a full FIFO: dropped, sticky overflow
    cyc(1'b1, 9, 109, 1'b0, 1'b0);
    check("ovf_set", ovf, 1);
    check("ovf_count", count, 8);
    for (int k = 0; k < 8; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("drain_empty", empty, 1);
    check("drain_outi", out_i, 0);
    check("ovf_sticky", ovf, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("ovf_clr", ovf, 0);

    // Full with simultaneous push and pull
    for (int k = 1; k <= 8; k++) cyc(1'b1, k, 100 + k, 1'b0, 1'b1);
    cyc(1'b1, 9, 109, 1'b1, 1'b1);
    check("fpp_count", count, 8);
    check("fpp_full", full, 1);
    check("fpp_outi", out_i, 2);
    check("fpp_ovf", ovf, 0);
    for (int k = 0; k < 8; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("fpp_empty", empty, 1);

    // Empty with simultaneous push and pull: no bypass, underflow
    cyc(1'b1, 5, 105, 1'b1, 1'b1);
    check("epp_count", count, 1);
    check("epp_outi", out_i, 5);
    check("epp_unf", unf, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("unf_clr", unf, 0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("epp_empty", empty, 1);

    // Empty pull sets underflow; a new error beats a same-cycle clear
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("unf_set", unf, 1);
    clr_err = 1'b1;
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("unf_clr_vs_err", unf, 1);
    tick(); clr_err = 1'b0;
    check("unf_clr2", unf, 0);

    // Steady Count=3 across pointer wrap
    for (int k = 0; k < 3; k++) cyc(1'b1, 200 + k, 300 + k, 1'b0, 1'b1);
    for (int k = 3; k < 23; k++) begin
      cyc(1'b1, 200 + k, 300 + k, 1'b1, 1'b1);
      check("wrap_count", count, 3);
      check("wrap_flags", {full, empty, afull, aempty, ovf, unf}, 0);
    end
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("wrap_empty", empty, 1);

    // Reset mid-operation beats a push
    for (int k = 0; k < 5; k++) cyc(1'b1, 40 + k, 50 + k, 1'b0, 1'b1);
    check("pre_rst_count", count, 5);
    reset = 1'b1;
    exp_q.delete();
    cyc(1'b1, 77, 88, 1'b0, 1'b0);
    reset = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_out", {out_i, out_q}, 0);
    check("mid_rst_err", {ovf, unf}, 0);

    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iq_samp_fifo.md
IQ_SAMP_FIFO -- requirements
Module: iq_samp_fifo

Interface
REQ-001 The block SHALL have parameter SAMP_W, default 24, giving the width of each I and Q component.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the entry count; legal values are powers of two, 4 to 256.
REQ-003 The block SHALL have parameter AFULL_TH, default DEPTH-2, giving the Count at or above which AlmostFull asserts.
REQ-004 The block SHALL have parameter AEMPTY_TH, default 2, giving the Count at or below which AlmostEmpty asserts.
REQ-005 The block SHALL have ports: Clk  in  1  single clock, rising edge; Reset  in  1  synchronous reset, active-high.
REQ-006 The block SHALL have ports: PushIn  in  1  write request; SampI  in  SAMP_W  I sample; SampQ  in  SAMP_W  Q sample.
REQ-007 The block SHALL have ports: PullOut  in  1  read request; OutI  out  SAMP_W  head I; OutQ  out  SAMP_W  head Q.
REQ-008 The block SHALL have ports: Full, Empty, AlmostFull, AlmostEmpty  out  1 each  status; Count  out  $clog2(DEPTH)+1  occupancy.
REQ-009 The block SHALL have ports: Overflow  out  1  sticky drop flag; Underflow  out  1  sticky empty-read flag; ClrErr  in  1  clears both sticky flags.

Function
REQ-010 Storage SHALL be DEPTH entries of {I,Q}; read and write pointers SHALL be $clog2(DEPTH)+1 bits, with the MSB as wrap bit.
REQ-011 Empty SHALL equal (rd_ptr == wr_ptr); Full SHALL be asserted when the low bits are equal and the wrap bits differ.
REQ-012 Count SHALL be a register equal to wr_ptr - rd_ptr (modulo arithmetic), updated on the same edge as the pointers.
REQ-013 Status flags SHALL be combinational from the registered pointers and Count, and valid in the cycle after the edge that changed them.
REQ-014 A push SHALL be accepted when PushIn=1 and (Full=0 or PullOut=1): the entry at wr_ptr is written and wr_ptr increments.
REQ-015 A pull SHALL be accepted when PullOut=1 and Empty=0; rd_ptr increments. A pull when Empty=1 SHALL NOT move rd_ptr.
REQ-016 Output SHALL be first-word-fall-through: OutI/OutQ show mem[rd_ptr] with zero latency when Empty=0, and all zeros when Empty=1.
REQ-017 Simultaneous push and pull when 0<Count<DEPTH SHALL leave Count unchanged; when Full, both SHALL be accepted and Full stays asserted.
REQ-018 Simultaneous push and pull when Empty SHALL accept the push, ignore the pull (no bypass), and set Underflow.
REQ-019 PushIn=1 while Full=1 and PullOut=0 SHALL drop the sample, leave memory and pointers unchanged, and set Overflow.
REQ-020 PullOut=1 while Empty=1 SHALL set Underflow.
REQ-021 Overflow and Underflow SHALL stay set until ClrErr=1. If ClrErr and a new error occur in the same cycle, the flag SHALL remain 1.
REQ-022 Pointer increments SHALL wrap naturally at 2*DEPTH with no special-case logic.

Reset
REQ-023 On Reset=1 at a rising Clk, rd_ptr, wr_ptr, Count, Overflow and Underflow SHALL be cleared to 0, giving Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, OutI=OutQ=0.
REQ-024 Reset SHALL take priority over PushIn, PullOut and ClrErr in the same cycle; contents mid-operation are discarded.
REQ-025 Memory contents SHALL NOT be reset; they are unobservable because output is masked while Empty.

Structure
REQ-026 The shared package SHALL hold the default SAMP_W and DEPTH constants, the parametrised {I,Q} sample typedef, and the count-width helper.
REQ-027 Storage SHALL be a sub-module iq_samp_ram (1 write port, 1 asynchronous read port), so it can later map to a vendor RAM.
REQ-028 The block SHALL elaborate assertions that DEPTH is a power of two and that AEMPTY_TH < AFULL_TH <= DEPTH.

Verification (DEPTH=8, SAMP_W=24)
REQ-029 Reset, then push I=1..8/Q=101..108 on 8 consecutive cycles -> Count=8, Full=1, AlmostFull=1 from Count=6, and OutI=1 throughout.
REQ-030 From full, push 9 with no pull -> Overflow=1, Count=8; pulling 8 times then yields I=1..8 in order, then Empty=1 and OutI=0.
REQ-031 From full, push 9 and pull on the same cycle -> Count=8, OutI=2, Overflow=0; draining yields 2..9.
REQ-032 Empty, push 5 and pull on the same cycle -> Count=1, OutI=5, Underflow=1; ClrErr pulse clears it -> Underflow=0.
REQ-033 Run 20 push/pull pairs with Count held at 3 across pointer wrap -> data order is preserved and no flags toggle.
REQ-034 Assert Reset at Count=5 together with PushIn=1 -> next cycle Count=0, Empty=1, Out=0, and the push is discarded.
